// File: rtl/gpio_cmd_ctrl_pkg.sv
// Shared constants for the GPIO command sequencer: opcodes, GPO/GPI bit layout
// and FSM state encoding.
package gpio_cmd_ctrl_pkg;

  localparam logic [7:0] OP_SOFT_RST = 8'h01;
  localparam logic [7:0] OP_WR_REG   = 8'h02;
  localparam logic [7:0] OP_RD_REG   = 8'h03;
  localparam logic [7:0] OP_LED_SET  = 8'h04;
  localparam logic [7:0] OP_SW_SNAP  = 8'h05;

  localparam int GPO_OP_LSB   = 24;
  localparam int GPO_STROBE   = 23;
  localparam int GPO_ADDR_MSB = 22;
  localparam int GPI_DONE     = 31;
  localparam int GPI_ERR      = 30;
  localparam int GPI_SW_LSB   = 24;
  localparam int NB_LEDS_RGB  = 12;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_SOFT_RST) || (op == OP_WR_REG) || (op == OP_RD_REG) ||
           (op == OP_LED_SET) || (op == OP_SW_SNAP);
  endfunction

endpackage

// File: rtl/gpio_cmd_ctrl_if.sv
// GPO/GPI word pair between the MicroBlaze GPIO block and the command sequencer.
interface gpio_cmd_ctrl_if #(parameter int NB_GPIOS = 32);

  logic [NB_GPIOS-1:0] gpo;
  logic [NB_GPIOS-1:0] gpi;

  modport master (output gpo, input gpi);
  modport slave  (input gpo, output gpi);

endinterface

// File: rtl/gpio_cmd_regfile.sv
// Configuration register file: one write port, one combinational read port and
// every register exposed on a flattened bus.
module gpio_cmd_regfile #(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we,
  input  logic [NB_ADDR-1:0]                waddr,
  input  logic [NB_DATA-1:0]                wdata,
  input  logic [NB_ADDR-1:0]                raddr,
  output logic [NB_DATA-1:0]                rdata,
  output logic [NB_DATA*(2**NB_ADDR)-1:0]   cfg
);

  localparam int NB_REGS = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] regs [NB_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NB_REGS; k++) begin
        regs[k] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

  for (genvar g = 0; g < NB_REGS; g++) begin : g_flat
    assign cfg[g*NB_DATA +: NB_DATA] = regs[g];
  end

endmodule

// File: rtl/gpio_cmd_ctrl.sv
// Command sequencer: decodes strobed command words from the micro's GPO bus,
// executes them and reports done/err/read data on the GPI bus.
module gpio_cmd_ctrl
  import gpio_cmd_ctrl_pkg::*;
#(
  parameter int NB_GPIOS        = 32,
  parameter int NB_DATA         = 16,
  parameter int NB_ADDR         = 3,
  parameter int NB_SW           = 4,
  parameter int SOFT_RST_CYCLES = 8
) (
  input  logic                              clockdsp,
  input  logic                              i_reset,
  gpio_cmd_ctrl_if.slave                    bus,
  input  logic [NB_SW-1:0]                  i_sw,
  output logic                              o_soft_reset,
  output logic [NB_LEDS_RGB-1:0]            o_leds_rgb,
  output logic [NB_DATA*(2**NB_ADDR)-1:0]   o_cfg
);

  localparam int CNT_W = $clog2(SOFT_RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SOFT_RST_CYCLES - 1);

  logic [NB_GPIOS-1:0] gpo_q;
  logic                gpo_valid;
  logic                strobe_prev;
  logic                strobe_edge;
  logic [1:0]          state;
  logic [7:0]          op;
  logic [NB_ADDR-1:0]  addr;
  logic [NB_DATA-1:0]  cmd_data;
  logic [CNT_W-1:0]    rst_cnt;
  logic                done;
  logic                err;
  logic [NB_SW-1:0]    sw_snap;
  logic [NB_DATA-1:0]  rdata;
  logic [NB_DATA-1:0]  reg_rdata;
  logic                reg_we;
  logic                unused_payload;

  assign unused_payload = ^gpo_q[GPO_ADDR_MSB-NB_ADDR:NB_DATA];

  // gpo_valid keeps strobe_prev pinned high until gpo_q holds a real sample,
  // so a strobe held through reset never looks like a fresh edge.
  always_ff @(posedge clockdsp) begin
    if (i_reset) begin
      gpo_q       <= '0;
      gpo_valid   <= 1'b0;
      strobe_prev <= 1'b1;
      strobe_edge <= 1'b0;
    end else begin
      gpo_q       <= bus.gpo;
      gpo_valid   <= 1'b1;
      if (gpo_valid) begin
        strobe_prev <= gpo_q[GPO_STROBE];
      end
      strobe_edge <= gpo_valid & gpo_q[GPO_STROBE] & ~strobe_prev;
    end
  end

  assign reg_we = (state == ST_EXEC) && (op == OP_WR_REG);

  gpio_cmd_regfile #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_regfile (
    .clk   (clockdsp),
    .rst   (i_reset),
    .we    (reg_we),
    .waddr (addr),
    .wdata (cmd_data),
    .raddr (addr),
    .rdata (reg_rdata),
    .cfg   (o_cfg)
  );

  always_ff @(posedge clockdsp) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      op           <= '0;
      addr         <= '0;
      cmd_data     <= '0;
      rst_cnt      <= '0;
      o_soft_reset <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      o_leds_rgb   <= '0;
      sw_snap      <= '0;
      rdata        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (strobe_edge) begin
            op       <= gpo_q[GPO_OP_LSB +: 8];
            addr     <= gpo_q[GPO_ADDR_MSB -: NB_ADDR];
            cmd_data <= gpo_q[NB_DATA-1:0];
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          rst_cnt <= '0;
          if (op == OP_SOFT_RST) begin
            o_soft_reset <= 1'b1;
          end
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          // Only SOFT_RST lingers here; it leaves once the pulse has lasted SOFT_RST_CYCLES.
          if ((op == OP_SOFT_RST) && (rst_cnt != CNT_LAST)) begin
            rst_cnt <= rst_cnt + CNT_W'(1);
          end else begin
            o_soft_reset <= 1'b0;
            done         <= 1'b1;
            err          <= ~is_known_op(op);
            state        <= ST_DONE;
            case (op)
              OP_RD_REG:  rdata <= reg_rdata;
              OP_LED_SET: o_leds_rgb <= cmd_data[NB_LEDS_RGB-1:0];
              OP_SW_SNAP: begin
                sw_snap <= i_sw;
                rdata   <= NB_DATA'(i_sw);
              end
              default: ;
            endcase
          end
        end
        ST_DONE: begin
          if (!gpo_q[GPO_STROBE]) begin
            done  <= 1'b0;
            err   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.gpi                           = '0;
    bus.gpi[GPI_DONE]                 = done;
    bus.gpi[GPI_ERR]                  = err;
    bus.gpi[GPI_SW_LSB +: NB_SW]      = sw_snap;
    bus.gpi[NB_DATA-1:0]              = rdata;
  end

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// Scoreboard bench for gpio_cmd_ctrl: commands push their expected GPI response,
// a monitor pops and compares on every rising done.
module tb_gpio_cmd_ctrl;
  import gpio_cmd_ctrl_pkg::*;

  localparam int SOFT_RST_CYCLES = 8;

  logic         clockdsp = 1'b0;
  logic         i_reset;
  logic [3:0]   i_sw;
  logic         o_soft_reset;
  logic [11:0]  o_leds_rgb;
  logic [127:0] o_cfg;

  gpio_cmd_ctrl_if #(.NB_GPIOS(32)) bus ();

  gpio_cmd_ctrl #(
    .NB_GPIOS        (32),
    .NB_DATA         (16),
    .NB_ADDR         (3),
    .NB_SW           (4),
    .SOFT_RST_CYCLES (SOFT_RST_CYCLES)
  ) dut (
    .clockdsp     (clockdsp),
    .i_reset      (i_reset),
    .bus          (bus),
    .i_sw         (i_sw),
    .o_soft_reset (o_soft_reset),
    .o_leds_rgb   (o_leds_rgb),
    .o_cfg        (o_cfg)
  );

  always #5 clockdsp = ~clockdsp;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [15:0] m_regs [8];
  logic [11:0] m_leds;
  logic [3:0]  m_sw;
  logic [15:0] m_rdata;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [127:0] cfgModel();
    logic [127:0] c;
    c = '0;
    for (int k = 0; k < 8; k++) c[k*16 +: 16] = m_regs[k];
    return c;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 8; k++) m_regs[k] = '0;
    m_leds  = '0;
    m_sw    = '0;
    m_rdata = '0;
  endtask

  // Updates the reference model, queues the expected GPI word and raises the strobe.
  task automatic applyStimulus(input logic [7:0] op, input logic [22:0] payload);
    logic err;
    err = 1'b0;
    case (op)
      8'h01: ;
      8'h02: m_regs[payload[22:20]] = payload[15:0];
      8'h03: m_rdata = m_regs[payload[22:20]];
      8'h04: m_leds = payload[11:0];
      8'h05: begin
        m_sw    = i_sw;
        m_rdata = {12'h000, i_sw};
      end
      default: err = 1'b1;
    endcase
    exp_q.push_back({1'b1, err, 2'b00, m_sw, 8'h00, m_rdata});
    @(negedge clockdsp);
    bus.gpo = {op, 1'b1, payload};
  endtask

  task automatic waitDone(input string name, input int exp_lat);
    int k;
    k = 0;
    while (!bus.gpi[31] && k < 40) begin
      @(posedge clockdsp);
      #1;
      k++;
    end
    checkOutput(name, k, exp_lat);
  endtask

  task automatic releaseStrobe();
    int k;
    @(negedge clockdsp);
    bus.gpo[23] = 1'b0;
    k = 0;
    while (bus.gpi[31] && k < 10) begin
      @(posedge clockdsp);
      #1;
      k++;
    end
    checkOutput("done_clear", bus.gpi[31], 1'b0);
    @(negedge clockdsp);
  endtask

  logic done_q = 1'b0;
  initial begin
    forever begin
      @(negedge clockdsp);
      if (i_reset) begin
        done_q = 1'b0;
      end else begin
        if (bus.gpi[31] && !done_q) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: got %0h expected no response", bus.gpi);
          end else begin
            checkOutput("gpi_resp", bus.gpi, exp_q.pop_front());
          end
        end
        done_q = bus.gpi[31];
      end
    end
  end

  initial begin
    int highs;
    logic last_sr;
    logic seen;

    i_reset = 1'b1;
    bus.gpo = '0;
    i_sw    = 4'h0;
    modelReset();
    repeat (3) @(posedge clockdsp);
    @(negedge clockdsp);
    checkOutput("rst_gpi", bus.gpi, 32'h0);
    checkOutput("rst_cfg", o_cfg, 128'h0);
    checkOutput("rst_leds", o_leds_rgb, 12'h0);
    checkOutput("rst_soft_reset", o_soft_reset, 1'b0);
    i_reset = 1'b0;
    repeat (2) @(negedge clockdsp);

    $display("[TB] write/read register file");
    applyStimulus(8'h02, {3'd5, 4'h0, 16'hBEEF});
    waitDone("lat_wr", 5);
    checkOutput("cfg_reg5", o_cfg[95:80], 16'hBEEF);
    checkOutput("cfg_after_wr", o_cfg, cfgModel());
    releaseStrobe();
    applyStimulus(8'h03, {3'd5, 20'h0});
    waitDone("lat_rd", 5);
    checkOutput("rdata_beef", bus.gpi[15:0], 16'hBEEF);
    checkOutput("err_rd", bus.gpi[30], 1'b0);
    releaseStrobe();
    applyStimulus(8'h02, {3'd2, 4'hF, 16'h1234});
    waitDone("lat_wr2", 5);
    checkOutput("cfg_reg2", o_cfg[47:32], 16'h1234);
    releaseStrobe();

    $display("[TB] LED set and illegal opcode");
    applyStimulus(8'h04, {11'h0, 12'h5C3});
    waitDone("lat_led", 5);
    checkOutput("leds_5c3", o_leds_rgb, 12'h5C3);
    releaseStrobe();
    applyStimulus(8'h7F, {3'd5, 4'h0, 16'hDEAD});
    waitDone("lat_bad", 5);
    checkOutput("bad_err", bus.gpi[30], 1'b1);
    checkOutput("bad_cfg", o_cfg, cfgModel());
    checkOutput("bad_leds", o_leds_rgb, m_leds);
    checkOutput("bad_soft_reset", o_soft_reset, 1'b0);
    releaseStrobe();

    $display("[TB] switch snapshot with a strobe edge landing while busy");
    i_sw = 4'b1010;
    applyStimulus(8'h05, 23'h0);
    @(negedge clockdsp);
    @(negedge clockdsp);
    bus.gpo[23] = 1'b0;
    @(negedge clockdsp);
    bus.gpo[23] = 1'b1;
    waitDone("lat_snap", 2);
    i_sw = 4'b0101;
    repeat (6) @(negedge clockdsp);
    checkOutput("snap_hold", bus.gpi, 32'h8A00000A);
    releaseStrobe();
    repeat (8) @(negedge clockdsp);
    checkOutput("snap_no_rerun", bus.gpi, 32'h0A00000A);

    $display("[TB] soft reset pulse");
    applyStimulus(8'h01, 23'h0);
    highs = 0;
    last_sr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clockdsp);
      if (bus.gpi[31]) begin
        seen = 1'b1;
        break;
      end
      if (o_soft_reset) highs++;
      last_sr = o_soft_reset;
    end
    checkOutput("sr_done_seen", seen, 1'b1);
    checkOutput("sr_pulse_len", highs, SOFT_RST_CYCLES);
    checkOutput("sr_high_before_done", last_sr, 1'b1);
    checkOutput("sr_low_at_done", o_soft_reset, 1'b0);
    releaseStrobe();

    $display("[TB] reset during soft reset");
    applyStimulus(8'h01, 23'h0);
    for (int i = 0; i < 20 && !o_soft_reset; i++) @(negedge clockdsp);
    checkOutput("abort_sr_started", o_soft_reset, 1'b1);
    repeat (2) @(negedge clockdsp);
    i_reset = 1'b1;
    exp_q.delete();
    modelReset();
    @(posedge clockdsp);
    #1;
    checkOutput("abort_soft_reset", o_soft_reset, 1'b0);
    checkOutput("abort_gpi", bus.gpi, 32'h0);
    checkOutput("abort_cfg", o_cfg, 128'h0);
    checkOutput("abort_leds", o_leds_rgb, 12'h0);
    @(negedge clockdsp);
    bus.gpo = '0;
    @(negedge clockdsp);
    i_reset = 1'b0;
    applyStimulus(8'h04, {11'h0, 12'h0F0});
    waitDone("lat_after_abort", 5);
    checkOutput("leds_after_abort", o_leds_rgb, 12'h0F0);
    releaseStrobe();

    $display("[TB] strobe held high through reset release");
    @(negedge clockdsp);
    i_reset = 1'b1;
    bus.gpo = {8'h04, 1'b1, 11'h0, 12'h123};
    exp_q.delete();
    modelReset();
    repeat (3) @(negedge clockdsp);
    i_reset = 1'b0;
    repeat (10) @(negedge clockdsp);
    checkOutput("held_no_done", bus.gpi[31], 1'b0);
    checkOutput("held_leds", o_leds_rgb, 12'h0);
    bus.gpo[23] = 1'b0;
    repeat (2) @(negedge clockdsp);
    applyStimulus(8'h04, {11'h0, 12'hA5A});
    waitDone("lat_led_a5a", 5);
    checkOutput("leds_a5a", o_leds_rgb, 12'hA5A);
    releaseStrobe();

    repeat (5) @(negedge clockdsp);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
